// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM transaction arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  function automatic logic [7:0] cmd_for(input logic wr);
    return wr ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/psram_arbiter_rr_select.sv
// rr_select: rotating priority encoder; first set req bit at or above ptr, with wrap.
module rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    idx = 0;
    sel = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[idx[IDX_W-1:0]]) begin
        any = 1'b1;
        sel = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller transaction port among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining PSRAM_ARB_TIMEOUT_EN.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]      req_size,
  input  logic [NUM_REQ-1:0]        req_wr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         psram_addr,
  output logic [DATA_W-1:0]         psram_data_i,
  output logic [2:0]                psram_size,
  output logic [7:0]                psram_cmd,
  output logic                      psram_rd_wr,
  output logic                      psram_start,
  input  logic                      psram_done,
  input  logic [DATA_W-1:0]         psram_data_o,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  arb_state_t        state, next_state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  sel;
  logic              any;
  logic              accept;
  logic              timed_out;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_size;
  logic              lat_wr;
  logic [IDX_W-1:0]  grant_q;
  logic [DATA_W-1:0] rdata_q;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_select (
    .req (req_valid),
    .ptr (rr_ptr),
    .sel (sel),
    .any (any)
  );

  assign accept = (state == IDLE) && any;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timed_out = (state == WAIT) && !psram_done && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == WAIT && psram_done)
        err_q <= 1'b0;
      else if (timed_out)
        err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (psram_done || timed_out) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept) req_ready[sel] = 1'b1;
    if (state == RESP) rsp_valid[grant_q] = 1'b1;
    psram_start = (state == ISSUE);
    busy        = (state != IDLE);
  end

  // Request fields are captured only on accept; later changes on the inputs are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_q   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_wr    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= req_addr[sel*ADDR_W +: ADDR_W];
        lat_wdata <= req_wdata[sel*DATA_W +: DATA_W];
        lat_size  <= req_size[sel*3 +: 3];
        lat_wr    <= req_wr[sel];
        grant_q   <= sel;
        rr_ptr    <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
      end
      if (state == WAIT) begin
        if (psram_done) begin
          if (!lat_wr) rdata_q <= psram_data_o;
        end else if (timed_out) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign psram_addr   = lat_addr;
  assign psram_data_i = lat_wdata;
  assign psram_size   = lat_size;
  assign psram_rd_wr  = lat_wr;
  assign psram_cmd    = cmd_for(lat_wr);
  assign rsp_rdata    = rdata_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a behavioural PSRAM controller model.
module tb_psram_arbiter;
  import psram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*3-1:0]  req_size = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   psram_addr;
  logic [DW-1:0]   psram_data_i;
  logic [2:0]      psram_size;
  logic [7:0]      psram_cmd;
  logic            psram_rd_wr;
  logic            psram_start;
  logic            psram_done = 1'b0;
  logic [DW-1:0]   psram_data_o = '0;
  logic            busy;
  logic [1:0]      grant_id;

  psram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_wr(req_wr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psram_addr(psram_addr), .psram_data_i(psram_data_i), .psram_size(psram_size),
    .psram_cmd(psram_cmd), .psram_rd_wr(psram_rd_wr), .psram_start(psram_start),
    .psram_done(psram_done), .psram_data_o(psram_data_o),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: done pulses ctl_lat negedges after start is seen.
  int          ctl_lat = 2;
  int          ctl_cnt = 0;
  int          done_cyc = -1;
  logic [31:0] ctl_data = '0;
  bit          ctl_en = 1'b1;
  bit          stray_done = 1'b0;

  always @(negedge clk) begin
    psram_done   = stray_done;
    psram_data_o = 32'h0BAD0BAD;
    if (rst) ctl_cnt = 0;
    else if (psram_start && ctl_en) ctl_cnt = ctl_lat;
    else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        psram_done   = 1'b1;
        psram_data_o = ctl_data;
        done_cyc     = cyc;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic set_fields(input int r, input logic [23:0] a, input logic [31:0] wd,
                            input logic [2:0] sz, input logic wr);
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = wd;
    req_size[r*3 +: 3]    = sz;
    req_wr[r]             = wr;
  endtask

  task automatic wait_ready(output int idx);
    idx = -2;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (req_ready != '0) begin
        idx = onehot_idx(req_ready);
        return;
      end
      step();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (rsp_valid != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    int          r;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] cdata;
    int          lat;
    logic [7:0]  ecmd;
    logic [31:0] erdata;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   idx, start_cyc, prev_start, s;
    bit   ok;
    int   expo[8];
    int   stray;

    tbl[0] = '{0, 24'h000100, 32'h00000000, SZ_HALF, 1'b0, 32'h0000ABCD, 10, 8'h03, 32'h0000ABCD};
    tbl[1] = '{2, 24'h001000, 32'hDEADBEEF, SZ_WORD, 1'b1, 32'h12345678, 3,  8'h02, 32'h0000ABCD};
    tbl[2] = '{3, 24'hFFFFFF, 32'h00000000, SZ_BYTE, 1'b0, 32'hCAFEF00D, 1,  8'h03, 32'hCAFEF00D};
    tbl[3] = '{1, 24'h123456, 32'h00000000, 3'd7,    1'b0, 32'h55AA55AA, 2,  8'h03, 32'h55AA55AA};
    tbl[4] = '{0, 24'h0ABCDE, 32'hA5A5A5A5, SZ_WORD, 1'b1, 32'h77777777, 5,  8'h02, 32'h55AA55AA};
    expo = '{0, 1, 2, 3, 0, 1, 2, 3};

    step(); step();
    chk("reset busy", busy, 0);
    chk("reset cmd", psram_cmd, 8'h03);
    chk("reset grant_id", grant_id, 0);
    chk("reset start", psram_start, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rdata", rsp_rdata, 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < 5; t++) begin
      ctl_lat  = tbl[t].lat;
      ctl_data = tbl[t].cdata;
      set_fields(tbl[t].r, tbl[t].addr, tbl[t].wdata, tbl[t].size, tbl[t].wr);
      req_valid = 4'b0001 << tbl[t].r;
      wait_ready(idx);
      chk($sformatf("v%0d ready idx", t), idx, tbl[t].r);
      step();
      req_valid = '0;
      set_fields(tbl[t].r, 24'h0, 32'h0, 3'd0, ~tbl[t].wr);
      chk($sformatf("v%0d start", t), psram_start, 1);
      chk($sformatf("v%0d addr", t), psram_addr, tbl[t].addr);
      chk($sformatf("v%0d size", t), psram_size, tbl[t].size);
      chk($sformatf("v%0d cmd", t), psram_cmd, tbl[t].ecmd);
      chk($sformatf("v%0d rd_wr", t), psram_rd_wr, tbl[t].wr);
      if (tbl[t].wr) chk($sformatf("v%0d data_i", t), psram_data_i, tbl[t].wdata);
      step();
      chk($sformatf("v%0d start pulse", t), psram_start, 0);
      chk($sformatf("v%0d addr held", t), psram_addr, tbl[t].addr);
      chk($sformatf("v%0d busy", t), busy, 1);
      wait_rsp(ok);
      chk($sformatf("v%0d rsp seen", t), ok, 1);
      chk($sformatf("v%0d rsp_valid", t), rsp_valid, 4'b0001 << tbl[t].r);
      chk($sformatf("v%0d done->rsp", t), cyc, done_cyc + 1);
      chk($sformatf("v%0d rdata", t), rsp_rdata, tbl[t].erdata);
      chk($sformatf("v%0d err", t), rsp_err, 0);
      chk($sformatf("v%0d grant_id", t), grant_id, tbl[t].r);
      step();
      chk($sformatf("v%0d idle busy", t), busy, 0);
      chk($sformatf("v%0d rsp one cycle", t), rsp_valid, 0);
    end

    // Stray done in IDLE must not start anything.
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step(); step();
    chk("stray done busy", busy, 0);
    chk("stray done rsp", rsp_valid, 0);

    // Fairness from a fresh pointer.
    rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < N; r++) set_fields(r, 24'(r * 256), 32'(r), SZ_WORD, 1'b0);
    ctl_lat = 2;
    ctl_data = 32'h0000F00D;
    req_valid = 4'b1111;
    prev_start = -100;
    for (int g = 0; g < 8; g++) begin
      wait_ready(idx);
      chk($sformatf("fair grant %0d", g), idx, expo[g]);
      step();
      start_cyc = cyc;
      chk($sformatf("fair addr %0d", g), psram_addr, 24'(expo[g] * 256));
      if (g > 0) chk($sformatf("fair spacing %0d", g), (start_cyc - prev_start) >= 4, 1);
      prev_start = start_cyc;
      wait_rsp(ok);
      chk($sformatf("fair rsp %0d", g), rsp_valid, 4'b0001 << expo[g]);
      step();
    end
    req_valid = '0;

    // Withdraw and late arrival.
    ctl_lat = 6;
    set_fields(3, 24'h003333, 32'h0, SZ_WORD, 1'b0);
    req_valid = 4'b1000;
    wait_ready(idx);
    chk("wd grant r3", idx, 3);
    step();
    req_valid = 4'b0010;
    set_fields(1, 24'h001111, 32'h0, SZ_WORD, 1'b0);
    step();
    chk("wd no ready in wait", req_ready, 0);
    step();
    req_valid = 4'b0001;
    set_fields(0, 24'h000777, 32'h0, SZ_WORD, 1'b0);
    wait_rsp(ok);
    chk("wd rsp r3", rsp_valid, 4'b1000);
    step();
    wait_ready(idx);
    chk("wd grant r0", idx, 0);
    step();
    req_valid = '0;
    chk("wd r0 addr", psram_addr, 24'h000777);
    wait_rsp(ok);
    chk("wd rsp r0", rsp_valid, 4'b0001);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (req_ready != '0 || busy) stray++;
    end
    chk("wd r1 never granted", stray, 0);

    // Reset mid-transaction, then pointer must be back at 0.
    ctl_lat = 50;
    set_fields(2, 24'h002222, 32'h0, SZ_WORD, 1'b0);
    req_valid = 4'b0100;
    wait_ready(idx);
    chk("rst grant r2", idx, 2);
    step();
    req_valid = '0;
    step();
    chk("rst in wait", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst grant_id", grant_id, 0);
    chk("rst cmd", psram_cmd, 8'h03);
    chk("rst addr", psram_addr, 0);
    stray = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (rsp_valid != '0 || busy) stray++;
    end
    chk("rst no late rsp", stray, 0);
    ctl_lat = 3;
    ctl_data = 32'h13572468;
    set_fields(0, 24'h000010, 32'h0, SZ_WORD, 1'b0);
    set_fields(3, 24'h000030, 32'h0, SZ_WORD, 1'b0);
    req_valid = 4'b1001;
    wait_ready(idx);
    chk("rst ptr zero", idx, 0);
    step();
    req_valid = 4'b1000;
    wait_rsp(ok);
    chk("rst after rsp", rsp_valid, 4'b0001);
    chk("rst after rdata", rsp_rdata, 32'h13572468);
    step();
    wait_ready(idx);
    chk("rst next r3", idx, 3);
    step();
    req_valid = '0;
    wait_rsp(ok);
    chk("rst r3 rsp", rsp_valid, 4'b1000);
    step();

`ifdef PSRAM_ARB_TIMEOUT_EN
    ctl_en = 1'b0;
    set_fields(1, 24'h00ABCD, 32'h0, SZ_WORD, 1'b0);
    req_valid = 4'b0010;
    wait_ready(idx);
    chk("to grant", idx, 1);
    step();
    s = cyc;
    req_valid = '0;
    wait_rsp(ok);
    chk("to rsp seen", ok, 1);
    chk("to latency", cyc, s + 17);
    chk("to rsp_valid", rsp_valid, 4'b0010);
    chk("to err", rsp_err, 1);
    chk("to rdata", rsp_rdata, 0);
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step(); step();
    chk("to late done busy", busy, 0);
    chk("to late done rsp", rsp_valid, 0);
    ctl_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
